// File: rtl/olink_bringup_if.sv
// Control/status bundle between the link bring-up sequencer and its surroundings.
// master drives the GT status inputs; slave is the sequencer.
interface olink_bringup_if;
    logic        enable;
    logic        restart;
    logic        qpll_lock;
    logic        clk_link_lock;
    logic        tx_fsm_done;
    logic        rx_fsm_done;
    logic        rx_reset_done;
    logic        rx_ok;
    logic        comma_seen;
    logic        soft_reset_tx;
    logic        soft_reset_rx;
    logic        link_up;
    logic        fail;
    logic [3:0]  state;
    logic [3:0]  retry_count;
    logic [15:0] drop_count;

    modport master (
        output enable, restart, qpll_lock, clk_link_lock, tx_fsm_done,
               rx_fsm_done, rx_reset_done, rx_ok, comma_seen,
        input  soft_reset_tx, soft_reset_rx, link_up, fail, state,
               retry_count, drop_count
    );

    modport slave (
        input  enable, restart, qpll_lock, clk_link_lock, tx_fsm_done,
               rx_fsm_done, rx_reset_done, rx_ok, comma_seen,
        output soft_reset_tx, soft_reset_rx, link_up, fail, state,
               retry_count, drop_count
    );
endinterface

// File: rtl/olink_bringup_fsm.sv
// GTX link bring-up and recovery sequencer: PLL lock wait, TX/RX soft reset,
// comma alignment, link-up monitoring and bounded retry.
module olink_bringup_fsm #(
    parameter int unsigned RESET_PULSE_CYCLES = 16,
    parameter int unsigned DONE_TIMEOUT       = 125000,
    parameter int unsigned ALIGN_WINDOW       = 1024,
    parameter int unsigned COMMAS_REQUIRED    = 8,
    parameter int unsigned MAX_BAD            = 4,
    parameter int unsigned MAX_RETRIES        = 7
) (
    input logic            clk_125,
    input logic            reset,
    olink_bringup_if.slave bus
);
    localparam int unsigned STATE_W = 4;
    localparam int unsigned TIMER_W = 24;
    localparam int unsigned COMMA_W = 8;
    localparam int unsigned BAD_W   = $clog2(MAX_BAD + 1);
    localparam int unsigned RETRY_W = 4;
    localparam int unsigned DROP_W  = 16;

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_WAIT_PLL = 4'd1;
    localparam logic [3:0] S_TX_RST   = 4'd2;
    localparam logic [3:0] S_TX_WAIT  = 4'd3;
    localparam logic [3:0] S_RX_RST   = 4'd4;
    localparam logic [3:0] S_RX_WAIT  = 4'd5;
    localparam logic [3:0] S_ALIGN    = 4'd6;
    localparam logic [3:0] S_UP       = 4'd7;
    localparam logic [3:0] S_FAIL     = 4'd8;

    localparam logic [TIMER_W-1:0] PULSE_LAST = TIMER_W'(RESET_PULSE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] DONE_LAST  = TIMER_W'(DONE_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] ALIGN_LAST = TIMER_W'(ALIGN_WINDOW - 1);

    logic [STATE_W-1:0] state, state_nxt;
    logic [TIMER_W-1:0] timer, timer_nxt;
    logic [COMMA_W-1:0] comma_cnt, comma_nxt;
    logic [BAD_W-1:0]   bad_cnt, bad_nxt;
    logic [RETRY_W-1:0] retry_cnt, retry_nxt;
    logic [DROP_W-1:0]  drop_cnt, drop_nxt;
    logic               entry;
    logic               timeout;
    logic [STATE_W-1:0] timeout_dest;
    logic               locks_ok;
    logic               soft_reset_tx_q, soft_reset_rx_q, link_up_q, fail_q;

    assign locks_ok = bus.qpll_lock & bus.clk_link_lock;

    // Next-state, counter and retry decisions; entry marks any transition, including self re-entry.
    always_comb begin
        state_nxt    = state;
        entry        = 1'b0;
        retry_nxt    = retry_cnt;
        drop_nxt     = drop_cnt;
        comma_nxt    = '0;
        bad_nxt      = '0;
        timeout      = 1'b0;
        timeout_dest = S_WAIT_PLL;

        if (bus.restart) begin
            state_nxt = S_IDLE;
            entry     = 1'b1;
            retry_nxt = '0;
            drop_nxt  = '0;
        end else if (!bus.enable) begin
            state_nxt = S_IDLE;
            entry     = (state != S_IDLE);
        end else if (!locks_ok && state >= S_TX_RST && state <= S_UP) begin
            state_nxt = S_WAIT_PLL;
            entry     = 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    state_nxt = S_WAIT_PLL;
                    entry     = 1'b1;
                end
                S_WAIT_PLL: begin
                    if (locks_ok) begin
                        state_nxt = S_TX_RST;
                        entry     = 1'b1;
                    end else if (timer == DONE_LAST) begin
                        timeout      = 1'b1;
                        timeout_dest = S_WAIT_PLL;
                    end
                end
                S_TX_RST: begin
                    if (timer == PULSE_LAST) begin
                        state_nxt = S_TX_WAIT;
                        entry     = 1'b1;
                    end
                end
                S_TX_WAIT: begin
                    if (bus.tx_fsm_done) begin
                        state_nxt = S_RX_RST;
                        entry     = 1'b1;
                    end else if (timer == DONE_LAST) begin
                        timeout      = 1'b1;
                        timeout_dest = S_WAIT_PLL;
                    end
                end
                S_RX_RST: begin
                    if (timer == PULSE_LAST) begin
                        state_nxt = S_RX_WAIT;
                        entry     = 1'b1;
                    end
                end
                S_RX_WAIT: begin
                    if (bus.rx_fsm_done && bus.rx_reset_done) begin
                        state_nxt = S_ALIGN;
                        entry     = 1'b1;
                    end else if (timer == DONE_LAST) begin
                        timeout      = 1'b1;
                        timeout_dest = S_RX_RST;
                    end
                end
                S_ALIGN: begin
                    // A dirty cycle clears the run even if a comma arrives with it.
                    if (!bus.rx_ok)
                        comma_nxt = '0;
                    else if (bus.comma_seen)
                        comma_nxt = comma_cnt + COMMA_W'(1);
                    else
                        comma_nxt = comma_cnt;
                    if (comma_nxt == COMMA_W'(COMMAS_REQUIRED)) begin
                        state_nxt = S_UP;
                        entry     = 1'b1;
                        retry_nxt = '0;
                    end else if (timer == ALIGN_LAST) begin
                        timeout      = 1'b1;
                        timeout_dest = S_RX_RST;
                    end
                end
                S_UP: begin
                    bad_nxt = bus.rx_ok ? '0 : bad_cnt + BAD_W'(1);
                    if (bad_nxt == BAD_W'(MAX_BAD)) begin
                        state_nxt = S_RX_RST;
                        entry     = 1'b1;
                        if (drop_cnt != '1)
                            drop_nxt = drop_cnt + DROP_W'(1);
                    end
                end
                S_FAIL: begin
                    state_nxt = S_FAIL;
                end
                default: begin
                    state_nxt = S_IDLE;
                    entry     = 1'b1;
                end
            endcase

            if (timeout) begin
                entry = 1'b1;
                if (retry_cnt == RETRY_W'(MAX_RETRIES)) begin
                    state_nxt = S_FAIL;
                end else begin
                    retry_nxt = retry_cnt + RETRY_W'(1);
                    state_nxt = timeout_dest;
                end
            end
        end

        if (entry) begin
            comma_nxt = '0;
            bad_nxt   = '0;
        end
        timer_nxt = entry ? '0 : timer + TIMER_W'(1);
    end

    // Outputs are registered alongside the state so they track it in the same cycle.
    always_ff @(posedge clk_125) begin
        if (reset) begin
            state           <= S_IDLE;
            timer           <= '0;
            comma_cnt       <= '0;
            bad_cnt         <= '0;
            retry_cnt       <= '0;
            drop_cnt        <= '0;
            soft_reset_tx_q <= 1'b0;
            soft_reset_rx_q <= 1'b0;
            link_up_q       <= 1'b0;
            fail_q          <= 1'b0;
        end else begin
            state           <= state_nxt;
            timer           <= timer_nxt;
            comma_cnt       <= comma_nxt;
            bad_cnt         <= bad_nxt;
            retry_cnt       <= retry_nxt;
            drop_cnt        <= drop_nxt;
            soft_reset_tx_q <= (state_nxt == S_TX_RST);
            soft_reset_rx_q <= (state_nxt == S_RX_RST);
            link_up_q       <= (state_nxt == S_UP);
            fail_q          <= (state_nxt == S_FAIL);
        end
    end

    assign bus.soft_reset_tx = soft_reset_tx_q;
    assign bus.soft_reset_rx = soft_reset_rx_q;
    assign bus.link_up       = link_up_q;
    assign bus.fail          = fail_q;
    assign bus.state         = state;
    assign bus.retry_count   = retry_cnt;
    assign bus.drop_count    = drop_cnt;
endmodule

// File: tb/tb_olink_bringup_fsm.sv
// Directed bench for olink_bringup_fsm: a per-row vector table plus hand-written
// sequences for bring-up latency, comma restart, retries/FAIL and reset/restart priority.
module tb_olink_bringup_fsm;
    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_WAIT_PLL = 4'd1;
    localparam logic [3:0] S_TX_RST   = 4'd2;
    localparam logic [3:0] S_TX_WAIT  = 4'd3;
    localparam logic [3:0] S_ALIGN    = 4'd6;
    localparam logic [3:0] S_UP       = 4'd7;
    localparam logic [3:0] S_FAIL     = 4'd8;

    typedef struct {
        logic [8:0]  in;     // {enable, restart, qpll, mmcm, tx_done, rx_done, rx_rst_done, rx_ok, comma}
        int          cycles;
        logic [3:0]  st;
        logic [3:0]  outs;   // {link_up, fail, soft_reset_tx, soft_reset_rx}
        logic [3:0]  rc;
        logic [15:0] dc;
    } vec_t;

    logic clk_125 = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;
    vec_t tbl [15];

    olink_bringup_if bus();

    olink_bringup_fsm #(
        .RESET_PULSE_CYCLES(16),
        .DONE_TIMEOUT      (20),
        .ALIGN_WINDOW      (64),
        .COMMAS_REQUIRED   (8),
        .MAX_BAD           (4),
        .MAX_RETRIES       (7)
    ) dut (
        .clk_125(clk_125),
        .reset  (reset),
        .bus    (bus.slave)
    );

    always #4 clk_125 = ~clk_125;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_125);
            #1;
        end
    endtask

    task automatic set_in(input logic [8:0] v);
        {bus.enable, bus.restart, bus.qpll_lock, bus.clk_link_lock, bus.tx_fsm_done,
         bus.rx_fsm_done, bus.rx_reset_done, bus.rx_ok, bus.comma_seen} = v;
    endtask

    task automatic wait_state(input logic [3:0] tgt, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk_125);
            #1;
            if (bus.state == tgt) break;
        end
        check(name, bus.state, tgt);
    endtask

    function automatic vec_t mk(input logic [8:0] in, input int cyc, input logic [3:0] st,
                                input logic [3:0] outs, input logic [3:0] rc, input logic [15:0] dc);
        vec_t v;
        v.in = in; v.cycles = cyc; v.st = st; v.outs = outs; v.rc = rc; v.dc = dc;
        return v;
    endfunction

    initial begin
        int lat, tx_hi, rx_hi, tx_pulses, rx_pulses;
        logic prev_tx, prev_rx;

        // Starting from UP: rx_ok glitches, link loss, lock loss, enable low, restart.
        tbl[0]  = mk(9'b1_0_11_111_0_1,  3, 4'd7, 4'b1000, 4'd0, 16'd0);
        tbl[1]  = mk(9'b1_0_11_111_1_1,  1, 4'd7, 4'b1000, 4'd0, 16'd0);
        tbl[2]  = mk(9'b1_0_11_111_0_1,  4, 4'd4, 4'b0001, 4'd0, 16'd1);
        tbl[3]  = mk(9'b1_0_11_111_1_1, 16, 4'd5, 4'b0000, 4'd0, 16'd1);
        tbl[4]  = mk(9'b1_0_11_111_1_1,  1, 4'd6, 4'b0000, 4'd0, 16'd1);
        tbl[5]  = mk(9'b1_0_11_111_1_1,  8, 4'd7, 4'b1000, 4'd0, 16'd1);
        tbl[6]  = mk(9'b1_0_01_111_1_1,  1, 4'd1, 4'b0000, 4'd0, 16'd1);
        tbl[7]  = mk(9'b1_0_11_111_1_1,  1, 4'd2, 4'b0010, 4'd0, 16'd1);
        tbl[8]  = mk(9'b1_0_11_111_1_1, 16, 4'd3, 4'b0000, 4'd0, 16'd1);
        tbl[9]  = mk(9'b1_0_11_111_1_1,  1, 4'd4, 4'b0001, 4'd0, 16'd1);
        tbl[10] = mk(9'b1_0_11_111_1_1, 16, 4'd5, 4'b0000, 4'd0, 16'd1);
        tbl[11] = mk(9'b1_0_11_111_1_1,  1, 4'd6, 4'b0000, 4'd0, 16'd1);
        tbl[12] = mk(9'b1_0_11_111_1_1,  8, 4'd7, 4'b1000, 4'd0, 16'd1);
        tbl[13] = mk(9'b0_0_11_111_1_1,  1, 4'd0, 4'b0000, 4'd0, 16'd1);
        tbl[14] = mk(9'b1_1_11_111_1_1,  1, 4'd0, 4'b0000, 4'd0, 16'd0);

        reset = 1'b1;
        set_in(9'b0);
        step(3);
        check("rst state", bus.state, 0);
        check("rst link_up", bus.link_up, 0);
        check("rst fail", bus.fail, 0);
        check("rst srtx", bus.soft_reset_tx, 0);
        check("rst srrx", bus.soft_reset_rx, 0);
        check("rst retry", bus.retry_count, 0);
        check("rst drop", bus.drop_count, 0);
        reset = 1'b0;
        step(1);

        // Minimum bring-up path: latency and pulse widths.
        set_in(9'b1_0_11_111_1_1);
        lat = 999; tx_hi = 0; rx_hi = 0; tx_pulses = 0; rx_pulses = 0;
        prev_tx = 1'b0; prev_rx = 1'b0;
        for (int e = 1; e <= 100; e++) begin
            step(1);
            if (bus.soft_reset_tx) tx_hi++;
            if (bus.soft_reset_rx) rx_hi++;
            if (bus.soft_reset_tx && !prev_tx) tx_pulses++;
            if (bus.soft_reset_rx && !prev_rx) rx_pulses++;
            prev_tx = bus.soft_reset_tx;
            prev_rx = bus.soft_reset_rx;
            if (bus.link_up) begin
                lat = e - 1;
                break;
            end
        end
        check("bringup latency", lat, 43);
        check("bringup srtx cycles", tx_hi, 16);
        check("bringup srrx cycles", rx_hi, 16);
        check("bringup srtx pulses", tx_pulses, 1);
        check("bringup srrx pulses", rx_pulses, 1);

        for (int i = 0; i < 15; i++) begin
            set_in(tbl[i].in);
            step(tbl[i].cycles);
            check($sformatf("row%0d state", i), bus.state, tbl[i].st);
            check($sformatf("row%0d link_up", i), bus.link_up, tbl[i].outs[3]);
            check($sformatf("row%0d fail", i), bus.fail, tbl[i].outs[2]);
            check($sformatf("row%0d srtx", i), bus.soft_reset_tx, tbl[i].outs[1]);
            check($sformatf("row%0d srrx", i), bus.soft_reset_rx, tbl[i].outs[0]);
            check($sformatf("row%0d retry", i), bus.retry_count, tbl[i].rc);
            check($sformatf("row%0d drop", i), bus.drop_count, tbl[i].dc);
        end

        // Comma run broken by a dirty cycle after 5 commas restarts from zero.
        set_in(9'b1_0_11_111_1_0);
        wait_state(S_ALIGN, 60, "comma reach align");
        set_in(9'b1_0_11_111_1_1);
        step(5);
        check("comma after 5", bus.state, S_ALIGN);
        set_in(9'b1_0_11_111_0_1);
        step(1);
        check("comma dirty cycle", bus.state, S_ALIGN);
        set_in(9'b1_0_11_111_1_1);
        step(7);
        check("comma 7 more state", bus.state, S_ALIGN);
        check("comma 7 more link", bus.link_up, 0);
        step(1);
        check("comma 8 more state", bus.state, S_UP);
        check("comma 8 more link", bus.link_up, 1);

        // Restart outranks lock loss.
        set_in(9'b1_1_01_111_1_1);
        step(1);
        check("restart+lockloss state", bus.state, S_IDLE);
        check("restart+lockloss link", bus.link_up, 0);

        // Reset mid TX pulse drops it; the next pulse is full width.
        set_in(9'b1_0_11_111_1_1);
        wait_state(S_TX_RST, 10, "reach tx_rst");
        step(3);
        check("mid pulse srtx", bus.soft_reset_tx, 1);
        reset = 1'b1;
        step(1);
        check("reset in tx_rst state", bus.state, S_IDLE);
        check("reset in tx_rst srtx", bus.soft_reset_tx, 0);
        reset = 1'b0;
        step(1);
        check("after reset state", bus.state, S_WAIT_PLL);
        tx_hi = 0;
        for (int e = 0; e < 40; e++) begin
            step(1);
            if (bus.soft_reset_tx) tx_hi++;
        end
        check("fresh pulse width", tx_hi, 16);

        // TX done stuck low: 7 retries then FAIL.
        set_in(9'b1_1_11_111_1_1);
        step(1);
        check("pre-fail retry", bus.retry_count, 0);
        set_in(9'b1_0_11_011_1_1);
        for (int k = 1; k <= 7; k++) begin
            wait_state(S_TX_WAIT, 40, $sformatf("loop%0d tx_wait", k));
            wait_state(S_WAIT_PLL, 40, $sformatf("loop%0d wait_pll", k));
            check($sformatf("loop%0d retry", k), bus.retry_count, k);
        end
        wait_state(S_TX_WAIT, 40, "loop8 tx_wait");
        wait_state(S_FAIL, 40, "loop8 fail state");
        check("fail flag", bus.fail, 1);
        check("fail retry", bus.retry_count, 7);
        step(5);
        check("fail held", bus.state, S_FAIL);
        set_in(9'b1_1_11_011_1_1);
        step(1);
        check("restart from fail state", bus.state, S_IDLE);
        check("restart from fail retry", bus.retry_count, 0);
        check("restart from fail flag", bus.fail, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
